uart_rx: RTL and testbench

Serial receiver that consumes the 8N1 bit stream produced by the team's UART transmitter, one start bit, 8 data bits LSB first, one stop bit, idle high. It sits between the FPGA rx pin and the host logic. It presents each received byte on a parallel bus with a one-cycle strobe and flags framing errors. Loopback with the transmitter (tx wired to rx) is the primary integration use.

---
 rtl/uart_rx_pkg.sv | 33 +++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: baud divisors for the 12 MHz board clock,
// baud counter width and the receiver state encoding. The tx and rx
// benches both decode the state values below.
package uart_rx_pkg;

    // Clock cycles per bit at 12 MHz
    localparam int unsigned B9600   = 1250;
    localparam int unsigned B19200  = 625;
    localparam int unsigned B57600  = 208;
    localparam int unsigned B115200 = 104;

    // Baud counter width; covers the legal divisor range 8..4095
    localparam int unsigned CNT_W = 12;

    // Receiver states, fixed encoding so external decoders stay valid
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_rx_state_t;

    // Counter load that places the first sample in the middle of the start bit
    function automatic logic [CNT_W-1:0] half_bit_load(input int unsigned baud);
        return CNT_W'(baud / 2 - 1);
    endfunction

    // Counter load for one full bit period
    function automatic logic [CNT_W-1:0] full_bit_load(input int unsigned baud);
        return CNT_W'(baud - 1);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin plus one extra
// flop to detect the falling edge that marks a start bit. All flops
// reset to 1 so a reset release on an idle line never fakes an edge.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    // Metastability filter followed by a one-cycle delay for edge detection
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_dly  <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_rx_s = r_sync;
    assign o_fall = r_dly & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Waits for a falling edge on the synchronized line,
// samples the start bit at mid-bit, then the eight data bits LSB first
// and the stop bit one bit period apart. A good stop bit updates data
// with a one-cycle rcv pulse; a low stop bit gives a one-cycle ferr pulse
// and leaves data untouched. Edges are only looked for while idle.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned BAUD = B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic       busy
);

    localparam logic [CNT_W-1:0] C_HALF = half_bit_load(BAUD);
    localparam logic [CNT_W-1:0] C_FULL = full_bit_load(BAUD);

    uart_rx_state_t   r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitc;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_rcv;
    logic             r_ferr;

    logic             w_rx_s;
    logic             w_fall;
    logic             w_tick;

    uart_rx_sync u_sync (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_rx   (rx),
        .o_rx_s (w_rx_s),
        .o_fall (w_fall)
    );

    // Sample point: the baud counter has run down to zero
    assign w_tick = (r_cnt == '0);

    // Frame FSM with inline baud counter, bit counter, shifter and output pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bitc  <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_rcv   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_rcv  <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Only a fresh falling edge arms a frame, so a stuck-low
                    // line after a framing error stays quiet
                    if (w_fall) begin
                        r_state <= ST_START;
                        r_cnt   <= C_HALF;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (!w_rx_s) begin
                            r_state <= ST_DATA;
                            r_cnt   <= C_FULL;
                            r_bitc  <= 3'd0;
                        end else begin
                            // Line is high again at mid start bit: a glitch
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        // LSB arrives first, so shift in at the top
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_bitc  <= r_bitc + 3'd1;
                        r_cnt   <= C_FULL;
                        if (r_bitc == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (w_rx_s) begin
                            r_data <= r_shift;
                            r_rcv  <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                        // Back to idle at once; the rest of the stop bit is
                        // the only gap needed before the next start edge
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data = r_data;
    assign rcv  = r_rcv;
    assign ferr = r_ferr;
    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 cycles per bit. A behavioural transmitter drives
// whole frames onto rx; for each frame a reference entry (good/bad stop,
// byte, cycle of the expected pulse) is queued from the frame timing rules,
// and a monitor matches every rcv/ferr pulse against the queue head.
module tb_uart_rx;

  localparam int unsigned BAUD = 16;
  // Pulse appears this many cycles after the cycle the start bit is driven:
  // 2 synchronizer flops, edge cycle, half bit, 9 full bits, 1 output register
  localparam int unsigned PULSE_LAT = 3 + BAUD / 2 + 9 * BAUD;

  logic       clk;
  logic       rstn;
  logic       rx;
  logic [7:0] data;
  logic       rcv;
  logic       ferr;
  logic       busy;

  int unsigned cyc;
  int          n_cmp;
  int          n_bad;

  logic [8:0]  exp_q[$];
  int unsigned exp_t_q[$];
  logic [7:0]  last_good;

  uart_rx #(.BAUD(BAUD)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .data (data),
    .rcv  (rcv),
    .ferr (ferr),
    .busy (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [8:0]  mon_e;
  int unsigned mon_t;
  always @(negedge clk) begin
    if (rstn && (rcv || ferr)) begin
      check("rcv_ferr_exclusive", {31'b0, rcv & ferr}, 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", 32'd0, 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        check("pulse_is_rcv", {31'b0, rcv}, {31'b0, mon_e[8]});
        check("pulse_is_ferr", {31'b0, ferr}, {31'b0, ~mon_e[8]});
        check("pulse_cycle", cyc, mon_t);
        if (mon_e[8]) last_good = mon_e[7:0];
        check("data_at_pulse", {24'b0, data}, {24'b0, last_good});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BAUD) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    exp_q.push_back({stop_bit, b});
    exp_t_q.push_back(cyc + PULSE_LAT);
    for (int i = 0; i < 10; i++) drive_bit(bits[i]);
  endtask

  // ---------------- stimulus ----------------
  int busy_cnt;
  int drain;
  logic [7:0] rb;
  logic       rbad;
  int         rgap;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_good = 8'h00;
    rx = 1'b1;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", {24'b0, data}, 32'h00);
    check("reset_rcv", {31'b0, rcv}, 32'd0);
    check("reset_ferr", {31'b0, ferr}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    rstn = 1'b1;
    idle(5);

    // Single frame, then directed boundary bytes
    send_frame(8'h55, 1'b1);
    idle(4);
    check("data_55", {24'b0, data}, 32'h55);
    send_frame(8'h00, 1'b1);
    idle(3);
    send_frame(8'hFF, 1'b1);
    idle(3);
    send_frame(8'h5A, 1'b1);
    idle(3);

    // Back-to-back frames, no idle between them
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    idle(10);
    check("data_b2b", {24'b0, data}, 32'h0F);

    // 3-cycle low glitch: START runs for half a bit, then gives up
    busy_cnt = 0;
    rx = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) rx = 1'b1;
      busy_cnt += busy;
    end
    check("glitch_busy_cycles", busy_cnt, 32'd8);
    check("glitch_data_kept", {24'b0, data}, 32'h0F);

    // Framing error, then line stays low: no new frame may start
    send_frame(8'hC4, 1'b0);
    busy_cnt = 0;
    for (int k = 0; k < 3 * BAUD; k++) begin
      @(posedge clk);
      #1;
      busy_cnt += busy;
    end
    check("stuck_low_busy", busy_cnt, 32'd0);
    check("data_after_ferr", {24'b0, data}, 32'h0F);
    idle(10);

    // Reset during data bit 4, then a clean frame
    rx = 1'b0;
    repeat (5 * BAUD + BAUD / 2) @(posedge clk);
    #1;
    check("busy_mid_frame", {31'b0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    check("midreset_data", {24'b0, data}, 32'h00);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_rcv", {31'b0, rcv}, 32'd0);
    check("midreset_ferr", {31'b0, ferr}, 32'd0);
    last_good = 8'h00;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(BAUD * 12);
    check("after_reset_data", {24'b0, data}, 32'h00);
    send_frame(8'h7E, 1'b1);
    idle(5);
    check("data_7e", {24'b0, data}, 32'h7E);

    // Randomized frames with random gaps and occasional bad stop bits
    for (int n = 0; n < 24; n++) begin
      rb   = 8'($urandom_range(0, 255));
      rbad = ($urandom_range(0, 7) == 0);
      rgap = rbad ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 12));
      send_frame(rb, ~rbad);
      idle(rgap);
    end

    // Drain with a bounded wait
    drain = 0;
    while (exp_q.size() != 0 && drain < 4 * BAUD * 10) begin
      @(posedge clk);
      #1;
      drain++;
    end
    check("queue_drained", exp_q.size(), 32'd0);
    idle(BAUD * 12);
    check("final_data", {24'b0, data}, {24'b0, last_good});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
